// File: rtl/sram_rr_arbiter.sv
// sram_rr_arbiter: two-requester round-robin sequencer in front of SRAM_32x128_1rw.
// Define SRAM_ARB_INIT_EN to zero-fill the macro after every reset.
module sram_rr_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk0,
  input  logic                  rst0_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0,
  output logic                  init_done
);

  logic                  run;
  logic                  init_wr;
  logic [ADDR_WIDTH-1:0] init_addr;
  logic                  last_grant;
  logic                  hs0;
  logic                  hs1;
  logic                  tag1_v;
  logic                  tag1_id;
  logic                  tag2_v;
  logic                  tag2_id;

`ifdef SRAM_ARB_INIT_EN
  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] init_addr_nxt;

  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      state     <= S_INIT;
      init_addr <= '0;
    end else begin
      state     <= state_nxt;
      init_addr <= init_addr_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    init_addr_nxt = init_addr;
    init_wr       = 1'b0;
    unique case (state)
      S_INIT: begin
        init_wr       = 1'b1;
        init_addr_nxt = init_addr + 1'b1;
        if (&init_addr) state_nxt = S_RUN;
      end
      S_RUN: state_nxt = S_RUN;
    endcase
  end

  assign run = rst0_n && (state == S_RUN);
`else
  assign init_wr   = 1'b0;
  assign init_addr = '0;
  assign run       = rst0_n;
`endif

  assign init_done = run;

  // tie goes to whoever was not granted last
  assign req0_ready = run & req0_valid & (~req1_valid | last_grant);
  assign req1_ready = run & req1_valid & (~req0_valid | ~last_grant);

  assign hs0 = req0_valid & req0_ready;
  assign hs1 = req1_valid & req1_ready;

  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      sram_csb0  <= 1'b1;
      sram_web0  <= 1'b1;
      sram_addr0 <= '0;
      sram_din0  <= '0;
    end else if (hs0) begin
      sram_csb0  <= 1'b0;
      sram_web0  <= ~req0_we;
      sram_addr0 <= req0_addr;
      sram_din0  <= req0_wdata;
    end else if (hs1) begin
      sram_csb0  <= 1'b0;
      sram_web0  <= ~req1_we;
      sram_addr0 <= req1_addr;
      sram_din0  <= req1_wdata;
    end else if (init_wr) begin
      sram_csb0  <= 1'b0;
      sram_web0  <= 1'b0;
      sram_addr0 <= init_addr;
      sram_din0  <= '0;
    end else begin
      sram_csb0  <= 1'b1;
      sram_web0  <= 1'b1;
    end
  end

  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      last_grant <= 1'b1;
      tag1_v     <= 1'b0;
      tag1_id    <= 1'b0;
      tag2_v     <= 1'b0;
      tag2_id    <= 1'b0;
    end else begin
      if (hs0 | hs1) last_grant <= hs1;
      tag1_v  <= (hs0 & ~req0_we) | (hs1 & ~req1_we);
      tag1_id <= hs1;
      tag2_v  <= tag1_v;
      tag2_id <= tag1_id;
    end
  end

  // tag reaches stage 2 in the cycle the macro presents dout
  assign rsp0_valid = tag2_v & ~tag2_id;
  assign rsp1_valid = tag2_v & tag2_id;
  assign rsp0_rdata = sram_dout0;
  assign rsp1_rdata = sram_dout0;

endmodule

// File: doc/sram_rr_arbiter.md
# sram_rr_arbiter

Two-port round-robin arbiter and sequencer for the single-port SRAM_32x128_1rw macro. It accepts independent read/write requests from two requesters over valid/ready handshakes, issues at most one SRAM access per cycle on registered macro controls, and returns read data tagged to the originating requester. It sits directly in front of the macro; requesters never drive csb0/web0 themselves.

## Interface
- DATA_WIDTH, 32, data word width
- ADDR_WIDTH, 7, address width; depth = 1 << ADDR_WIDTH
- clk0  in  1  clock, also drives the macro's clk0
- rst0_n  in  1  asynchronous reset, active-low; one clock
- reqN_valid  in  1  request valid, N = 0,1
- reqN_ready  out  1  request accepted this cycle (handshake = valid & ready)
- reqN_we  in  1  1 = write, 0 = read
- reqN_addr  in  ADDR_WIDTH  word address
- reqN_wdata  in  DATA_WIDTH  write data
- rspN_valid  out  1  read data valid, one-cycle pulse
- rspN_rdata  out  DATA_WIDTH  read data, valid only with rspN_valid
- sram_csb0  out  1  to macro csb0, active-low
- sram_web0  out  1  to macro web0, active-low
- sram_addr0  out  ADDR_WIDTH  to macro addr0
- sram_din0  out  DATA_WIDTH  to macro din0
- sram_dout0  in  DATA_WIDTH  from macro dout0
- init_done  out  1  high once the block accepts requests

## Operation
- States: INIT (only with macro, see Configuration) -> RUN. Reset returns to the first state.
- RUN arbitration: reqN_ready is combinational from valids and pointer; at most one ready high per cycle.
- Only one valid -> that requester granted regardless of pointer.
- Both valid -> grant requester != last_grant; last_grant updates only on a handshake. Reset value of last_grant = 1 (requester 0 wins first tie).
- Neither valid -> sram_csb0 = 1 next cycle, pointer unchanged.
- Handshake registers sram_csb0=0, sram_web0=~we, sram_addr0, sram_din0 on the same edge.
- Reads: 2-stage tag pipeline (valid + requester id) follows the access; response drives rspN_rdata = sram_dout0.
- Writes produce no response.
- No response backpressure; requesters must accept rspN_valid when it pulses.
- Accesses complete in issue order; write then read to the same address (any requester) returns the new data.
- Reset values: reqN_ready=0, rspN_valid=0, rspN_rdata follows sram_dout0 (don't care), sram_csb0=1, sram_web0=1, sram_addr0=0, sram_din0=0, init_done=0.
- Reset mid-operation: in-flight tags cleared, no response emitted for dropped reads; SRAM contents undefined for a write cut by reset.

## Timing
- Handshake at edge of cycle T: macro controls valid during T+1, macro samples at end of T+1.
- Read: rspN_valid high in cycle T+2 (latency 2), sram_dout0 valid in that cycle.
- Throughput: one access per cycle sustained; alternating grants under continuous contention.
- reqN_ready may be high in the first cycle after rst0_n deasserts (RUN, macro off); init_done=1 from that cycle.

## Configuration
- SRAM_ARB_INIT_EN defined: after reset enter INIT; issue 128 (depth) writes of zero to addresses 0..depth-1, one per cycle, ascending, both reqN_ready=0; after the last write is issued, next cycle enter RUN and init_done=1 (held until reset). Total: init_done rises depth+1 cycles after reset release.
- Undefined: no INIT state, SRAM contents untouched, RUN and init_done=1 immediately after reset.

## Test plan
- Req0 write 0xFACECAFE @10, then req0 read @10 -> rsp0_valid exactly 2 cycles after read handshake, rsp0_rdata=0xFACECAFE, rsp1_valid stays 0.
- Both valid every cycle, req0 reads @1, req1 reads @2 (preloaded 0x11111111/0x22222222) -> grants alternate 0,1,0,1 starting with 0; responses alternate with correct data, one per cycle.
- Req1 write 0xDEADBEEF @127 in cycle T, req0 read @127 in T+1 -> rsp0_rdata=0xDEADBEEF at T+3.
- Idle cycle between requests -> sram_csb0=1 in that slot; pointer unchanged (tie after single req0 grant goes to req1).
- rst0_n asserted with two reads in flight -> no rspN_valid pulse, all outputs at reset values asynchronously.
- With SRAM_ARB_INIT_EN: reset, wait for init_done (129 cycles), read @0 and @127 -> data 0x00000000; ready low throughout INIT.
